// File: rtl/fpadd_share_scheduler_if.sv
// rtl/fpadd_share_scheduler_if.sv - requester, shared-adder and response signals of the FP16 add scheduler
interface fpadd_share_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DWIDTH  = 16
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DWIDTH-1:0] req_a;
  logic [NUM_REQ*DWIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]        req_sub;
  logic                      add_valid;
  logic [DWIDTH-1:0]         add_a;
  logic [DWIDTH-1:0]         add_b;
  logic                      add_op;
  logic [DWIDTH-1:0]         add_result;
  logic [4:0]                add_flags;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [NUM_REQ-1:0]        resp_ready;
  logic [NUM_REQ*DWIDTH-1:0] resp_result;
  logic [NUM_REQ*5-1:0]      resp_flags;
  logic                      idle;

  modport slave (
    input  req_valid, req_a, req_b, req_sub, add_result, add_flags, resp_ready,
    output req_ready, add_valid, add_a, add_b, add_op, resp_valid, resp_result, resp_flags, idle
  );

  modport master (
    output req_valid, req_a, req_b, req_sub, add_result, add_flags, resp_ready,
    input  req_ready, add_valid, add_a, add_b, add_op, resp_valid, resp_result, resp_flags, idle
  );
endinterface

// File: rtl/fpadd_share_scheduler.sv
// rtl/fpadd_share_scheduler.sv - round-robin sharing of one pipelined FP16 adder among NUM_REQ requesters
module fpadd_share_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int DWIDTH      = 16,
  parameter int ADD_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  fpadd_share_scheduler_if.slave bus
);
  localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TDEPTH = ADD_LATENCY + 1;
  localparam logic [IDW-1:0] LAST_IDX = IDW'(NUM_REQ - 1);

  logic [NUM_REQ-1:0]          busy_q, busy_d;
  logic [IDW-1:0]              last_grant_q;
  logic                        add_valid_q;
  logic [DWIDTH-1:0]           add_a_q, add_b_q;
  logic                        add_op_q;
  logic [TDEPTH-1:0]           tag_valid_q;
  logic [TDEPTH-1:0][IDW-1:0]  tag_id_q;
  logic [NUM_REQ-1:0]          resp_valid_q, resp_valid_d;
  logic [NUM_REQ*DWIDTH-1:0]   resp_result_q, resp_result_d;
  logic [NUM_REQ*5-1:0]        resp_flags_q, resp_flags_d;

  logic [NUM_REQ-1:0]          eligible, grant;
  logic [IDW-1:0]              grant_id, out_id;
  logic                        accept;
  logic [DWIDTH-1:0]           sel_a, sel_b;
  logic                        sel_op;

  // Cyclic search starting just after the last grant; a fresh grant therefore ranks last next cycle.
  always_comb begin
    int             idx;
    logic [IDW-1:0] cand;
    logic           found;
    eligible = bus.req_valid & ~busy_q;
    grant_id = last_grant_q;
    found    = 1'b0;
    idx      = 0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_grant_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IDW'(idx);
      if (!found && eligible[cand]) begin
        found    = 1'b1;
        grant_id = cand;
      end
    end
    accept = found & ~reset;
    grant  = accept ? (NUM_REQ'(1) << grant_id) : '0;
  end

  assign out_id = tag_id_q[TDEPTH-1];

  always_comb begin
    busy_d        = (busy_q & ~(resp_valid_q & bus.resp_ready)) | grant;
    resp_valid_d  = resp_valid_q & ~bus.resp_ready;
    resp_result_d = resp_result_q;
    resp_flags_d  = resp_flags_q;
    sel_a         = '0;
    sel_b         = '0;
    sel_op        = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IDW'(i)) begin
        sel_a  = bus.req_a[i*DWIDTH +: DWIDTH];
        sel_b  = bus.req_b[i*DWIDTH +: DWIDTH];
        sel_op = bus.req_sub[i];
      end
      // Busy blocks re-issue until handshake, so a capture never lands on a held response.
      if (tag_valid_q[TDEPTH-1] && out_id == IDW'(i)) begin
        resp_valid_d[i]                  = 1'b1;
        resp_result_d[i*DWIDTH +: DWIDTH] = bus.add_result;
        resp_flags_d[i*5 +: 5]           = bus.add_flags;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q        <= '0;
      last_grant_q  <= LAST_IDX;
      add_valid_q   <= 1'b0;
      add_a_q       <= '0;
      add_b_q       <= '0;
      add_op_q      <= 1'b0;
      tag_valid_q   <= '0;
      tag_id_q      <= '0;
      resp_valid_q  <= '0;
      resp_result_q <= '0;
      resp_flags_q  <= '0;
    end else begin
      busy_q      <= busy_d;
      add_valid_q <= accept;
      if (accept) begin
        last_grant_q <= grant_id;
        add_a_q      <= sel_a;
        add_b_q      <= sel_b;
        add_op_q     <= sel_op;
      end
      tag_valid_q   <= {tag_valid_q[TDEPTH-2:0], accept};
      tag_id_q      <= {tag_id_q[TDEPTH-2:0], grant_id};
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
      resp_flags_q  <= resp_flags_d;
    end
  end

  assign bus.req_ready   = grant;
  assign bus.add_valid   = add_valid_q;
  assign bus.add_a       = add_a_q;
  assign bus.add_b       = add_b_q;
  assign bus.add_op      = add_op_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_result = resp_result_q;
  assign bus.resp_flags  = resp_flags_q;
  assign bus.idle        = ~|busy_q & ~|tag_valid_q;
endmodule
